// File: rtl/lcd_write_queue.sv
// Byte FIFO that decouples the MiniAlu LCD opcode from the LCD driver's write_Enabled/ready handshake.
// Optional sticky overflow flag is built when LCD_QUEUE_OVERFLOW_FLAG_EN is defined.
module lcd_write_queue #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         iPush,
  input  logic [DATA_WIDTH-1:0]        iData,
  output logic                         oFull,
  output logic                         oEmpty,
  output logic [$clog2(DEPTH+1)-1:0]   oCount,
  input  logic                         iLCD_Initialized,
  input  logic                         iLCD_Ready,
  output logic                         oLCD_WriteEnable,
  output logic [DATA_WIDTH-1:0]        oLCD_Data,
  input  logic                         iClearOverflow,
  output logic                         oOverflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wp, r_rp;
  logic [CNT_W-1:0]      r_count;
  logic [TMR_W-1:0]      r_timer, w_timer_next;
  logic                  r_we, w_we_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic                  w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop on the same edge frees the head slot, so a push at full still lands.
  assign w_push  = iPush && (!w_full || w_pop);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_we_next    = 1'b0;
    w_data_next  = r_data;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && iLCD_Initialized && iLCD_Ready) begin
          w_state_next = ISSUE;
          w_we_next    = 1'b1;
          w_data_next  = r_mem[r_rp];
        end
      end
      ISSUE: begin
        w_state_next = WAIT_BUSY;
        w_timer_next = '0;
      end
      WAIT_BUSY: begin
        // Timeout covers a driver that completes before ready is ever seen low.
        if (!iLCD_Ready || (r_timer == TIMER_LAST)) w_state_next = WAIT_DONE;
        else                                        w_timer_next = r_timer + TMR_W'(1);
      end
      WAIT_DONE: begin
        if (iLCD_Ready) begin
          w_state_next = IDLE;
          w_pop        = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_we    <= w_we_next;
      r_data  <= w_data_next;
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage array has no reset; its contents are only read after being written.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wp] <= iData;
  end

`ifdef LCD_QUEUE_OVERFLOW_FLAG_EN
  logic r_overflow;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                          r_overflow <= 1'b0;
    else if (iPush && w_full && !w_pop)    r_overflow <= 1'b1;
    else if (iClearOverflow)               r_overflow <= 1'b0;
  end
  assign oOverflow = r_overflow;
`else
  logic w_unused_clear;
  assign w_unused_clear = iClearOverflow;
  assign oOverflow      = 1'b0;
`endif

  assign oFull            = w_full;
  assign oEmpty           = w_empty;
  assign oCount           = r_count;
  assign oLCD_WriteEnable = r_we;
  assign oLCD_Data        = r_data;
endmodule

// File: tb/tb_lcd_write_queue.sv
// Directed and randomized bench for lcd_write_queue with a queue-based scoreboard and an LCD ready model.
module tb_lcd_write_queue;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int BT    = 8;
`ifdef LCD_QUEUE_OVERFLOW_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          iPush;
  logic [DW-1:0] iData;
  logic          oFull, oEmpty;
  logic [4:0]    oCount;
  logic          iLCD_Initialized;
  logic          iLCD_Ready = 1'b1;
  logic          oLCD_WriteEnable;
  logic [DW-1:0] oLCD_Data;
  logic          iClearOverflow;
  logic          oOverflow;

  lcd_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .iPush(iPush), .iData(iData),
    .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount),
    .iLCD_Initialized(iLCD_Initialized), .iLCD_Ready(iLCD_Ready),
    .oLCD_WriteEnable(oLCD_WriteEnable), .oLCD_Data(oLCD_Data),
    .iClearOverflow(iClearOverflow), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge Clock) cyc++;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            strobe_cyc[$];
  int            lcd_busy_cycles = 0;
  bit            lcd_rand_busy   = 1'b0;
  int            busy_cnt        = 0;
  int            dbl_strobe      = 0;
  int            glitches        = 0;
  logic          prev_we         = 1'b0;
  logic [DW-1:0] prev_data       = '0;

  // LCD model: captures each strobe, then holds ready low for the chosen busy time.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      busy_cnt  = 0;
      prev_we   = 1'b0;
      prev_data = '0;
    end else begin
      if (oLCD_WriteEnable) begin
        if (prev_we) dbl_strobe++;
        got_q.push_back(oLCD_Data);
        strobe_cyc.push_back(cyc);
        busy_cnt = lcd_rand_busy ? int'($urandom_range(0, 6)) : lcd_busy_cycles;
      end else begin
        if (oLCD_Data !== prev_data) glitches++;
        if (busy_cnt > 0) busy_cnt--;
      end
      prev_we   = oLCD_WriteEnable;
      prev_data = oLCD_Data;
    end
    iLCD_Ready = (busy_cnt == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(oEmpty === 1'b1 && iLCD_Ready === 1'b1) && n < 3000) begin
      step();
      n++;
    end
    check(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (oLCD_WriteEnable !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    check(tag, 32'(n < 500), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
    strobe_cyc.delete();
  endtask

  // Throttled push keeping the queue below full, bookkeeping only strobes seen.
  task automatic push_throttled(input logic [DW-1:0] d, output bit done);
    done = 1'b0;
    if (exp_q.size() - got_q.size() < DEPTH - 1) begin
      iPush = 1'b1;
      iData = d;
      exp_q.push_back(d);
      done  = 1'b1;
    end
    step();
    iPush = 1'b0;
  endtask

  initial begin
    bit ok;
    int base;
    Reset_n = 1'b0; iPush = 1'b0; iData = '0; iLCD_Initialized = 1'b0; iClearOverflow = 1'b0;
    repeat (3) step();
    check("rst_count", 32'(oCount), 32'd0);
    check("rst_empty", 32'(oEmpty), 32'd1);
    check("rst_full",  32'(oFull),  32'd0);
    check("rst_we",    32'(oLCD_WriteEnable), 32'd0);
    check("rst_data",  32'(oLCD_Data), 32'd0);
    check("rst_ovf",   32'(oOverflow), 32'd0);
    Reset_n = 1'b1;
    step();

    // Ordered burst with 20-cycle busy; also checks issue latency after the first push.
    iLCD_Initialized = 1'b1; lcd_busy_cycles = 20;
    iPush = 1'b1; iData = 8'h48; exp_q.push_back(8'h48);
    step();
    check("lat_edge_k", 32'(oLCD_WriteEnable), 32'd0);
    check("lat_count",  32'(oCount), 32'd1);
    iData = 8'h4F; exp_q.push_back(8'h4F);
    step();
    check("lat_edge_k1", 32'(oLCD_WriteEnable), 32'd1);
    check("lat_data",    32'(oLCD_Data), 32'h48);
    iData = 8'h4C; exp_q.push_back(8'h4C);
    step();
    iData = 8'h41; exp_q.push_back(8'h41);
    step();
    iPush = 1'b0;
    wait_drain("order_drain");
    check("order_count", 32'(oCount), 32'd0);
    compare_stream("order");

    // Reset asserted while the strobe is high.
    lcd_busy_cycles = 3;
    iPush = 1'b1; iData = 8'h11; step(); iData = 8'h22; step(); iPush = 1'b0;
    wait_strobe("rst_mid_wait");
    Reset_n = 1'b0;
    #1;
    check("rst_mid_we",    32'(oLCD_WriteEnable), 32'd0);
    check("rst_mid_count", 32'(oCount), 32'd0);
    check("rst_mid_empty", 32'(oEmpty), 32'd1);
    check("rst_mid_data",  32'(oLCD_Data), 32'd0);
    step();
    exp_q.delete(); got_q.delete(); strobe_cyc.delete();
    Reset_n = 1'b1;
    step();

    // Fill with LCD uninitialized; 17th byte is dropped.
    iLCD_Initialized = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      iPush = 1'b1; iData = 8'hA0 + 8'(i);
      if (i < DEPTH) exp_q.push_back(iData);
      step();
    end
    iPush = 1'b0;
    check("full_flag",  32'(oFull),  32'd1);
    check("full_count", 32'(oCount), 32'd16);
    check("full_we",    32'(oLCD_WriteEnable), 32'd0);
    check("ovf_set",    32'(oOverflow), 32'(OVF_EN));
    step();
    check("ovf_sticky", 32'(oOverflow), 32'(OVF_EN));
    iClearOverflow = 1'b1; step(); iClearOverflow = 1'b0;
    check("ovf_clear",  32'(oOverflow), 32'd0);

    // Push on the same edge as a pop while full.
    lcd_busy_cycles = 30;
    iLCD_Initialized = 1'b1;
    wait_strobe("pp_strobe");
    base = 0;
    while (busy_cnt != 1 && base < 200) begin step(); base++; end
    check("pp_wait", 32'(base < 200), 32'd1);
    iPush = 1'b1; iData = 8'h5A; exp_q.push_back(8'h5A);
    step();
    iPush = 1'b0;
    check("pp_count", 32'(oCount), 32'd16);
    check("pp_full",  32'(oFull),  32'd1);
    check("pp_ovf",   32'(oOverflow), 32'd0);
    lcd_busy_cycles = 3;
    wait_drain("pp_drain");
    compare_stream("pp");

    // Timeout path: ready never drops.
    lcd_busy_cycles = 0;
    iPush = 1'b1; iData = 8'hC1; exp_q.push_back(8'hC1); step();
    iData = 8'hC2; exp_q.push_back(8'hC2); step(); iPush = 1'b0;
    wait_strobe("to_first");
    repeat (9) step();
    check("to_hold_count", 32'(oCount), 32'd2);
    step();
    check("to_pop_count",  32'(oCount), 32'd1);
    check("to_gap_we",     32'(oLCD_WriteEnable), 32'd0);
    step();
    check("to_next_we",    32'(oLCD_WriteEnable), 32'd1);
    wait_drain("to_drain");
    check("to_spacing", 32'(strobe_cyc.size() == 2 ? strobe_cyc[1] - strobe_cyc[0] : -1), 32'd11);
    compare_stream("to");

    // Pointer wrap: 40 sequential bytes.
    lcd_rand_busy = 1'b1;
    for (int v = 0; v < 40; ) begin
      push_throttled(8'(v), ok);
      if (ok) v++;
    end
    wait_drain("wrap_drain");
    compare_stream("wrap");

    // Random pushes, data, busy times and initialization toggles.
    for (int i = 0; i < 300; i++) begin
      iLCD_Initialized = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) != 0) push_throttled(8'($urandom), ok);
      else step();
    end
    iLCD_Initialized = 1'b1;
    wait_drain("rand_drain");
    check("rand_ovf",   32'(oOverflow), 32'd0);
    check("rand_count", 32'(oCount), 32'd0);
    compare_stream("rand");

    check("single_strobe", 32'(dbl_strobe), 32'd0);
    check("data_stable",   32'(glitches), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
